data_mem_arbiter: RTL and testbench

// Shares port A of the data-segment block RAM between two requesters: the CPU load/store unit (c_*) and the debug/loader master (d_*).

---
 rtl/data_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter : shares DataRam port A between CPU LSU and debug master
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU load/store unit
  input  logic        c_valid_i,
  output logic        c_ready_o,
  input  logic [31:0] c_addr_i,
  input  logic [3:0]  c_we_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_rvalid_o,
  output logic [31:0] c_rdata_o,
  output logic        c_err_o,
  // debug / loader master
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_we_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  // DataRam port A
  output logic [29:0] mem_addr_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q;        // 1 = debug master owns the current access
  logic        last_d_q;       // 1 = debug master was granted last
  logic [29:0] mem_addr_q;
  logic [31:0] mem_wd_q;
  logic [3:0]  we_q;
  logic        err_q;

  logic        grant_c, grant_d;
  logic        hs;
  logic [31:0] sel_addr;
  logic [3:0]  sel_we;
  logic [31:0] sel_wdata;
  logic [1:0]  sel_off;
  logic [7:0]  mask8;
  logic        misaligned;
  logic [3:0]  lane_we;

  // CPU takes a tie when priority is fixed or when debug was served last.
  assign grant_c = c_valid_i & (~d_valid_i | (PRIO_MODE != 0) | last_d_q);
  assign grant_d = d_valid_i & ~grant_c;

  assign sel_addr  = grant_c ? c_addr_i  : d_addr_i;
  assign sel_we    = grant_c ? c_we_i    : d_we_i;
  assign sel_wdata = grant_c ? c_wdata_i : d_wdata_i;
  assign sel_off   = sel_addr[1:0];

  // A mask shifted past lane 3 would straddle words; such stores are refused.
  assign mask8      = {4'b0000, sel_we} << sel_off;
  assign misaligned = (sel_we != 4'b0000) && (mask8[7:4] != 4'b0000);
  assign lane_we    = misaligned ? 4'b0000 :
                      (sel_we == 4'b1111) ? 4'b1111 : mask8[3:0];

  always_comb begin
    state_d   = state_q;
    c_ready_o = 1'b0;
    d_ready_o = 1'b0;
    hs        = 1'b0;
    case (state_q)
      S_IDLE: begin
        c_ready_o = rst_n & grant_c;
        d_ready_o = rst_n & grant_d;
        hs        = rst_n & (grant_c | grant_d);
        if (hs) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_d_q   <= 1'b1;
      mem_addr_q <= 30'd0;
      mem_wd_q   <= 32'd0;
      we_q       <= 4'b0000;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q    <= grant_d;
        last_d_q   <= grant_d;
        mem_addr_q <= sel_addr[31:2];
        mem_wd_q   <= sel_wdata << {sel_off, 3'b000};
        we_q       <= lane_we;
        err_q      <= misaligned;
      end
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign mem_wd_o   = mem_wd_q;
  assign mem_we_o   = (state_q == S_ISSUE) ? we_q : 4'b0000;

  assign c_rvalid_o = (state_q == S_RESP) & ~owner_q;
  assign d_rvalid_o = (state_q == S_RESP) &  owner_q;
  assign c_rdata_o  = c_rvalid_o ? mem_rd_i : 32'd0;
  assign d_rdata_o  = d_rvalid_o ? mem_rd_i : 32'd0;
  assign c_err_o    = c_rvalid_o & err_q;
  assign d_err_o    = d_rvalid_o & err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// tb_data_mem_arbiter : directed + random checks against a byte-lane memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_valid, d_valid;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic [3:0]  c_we, d_we;

  logic        c_ready, c_rvalid, c_err, d_ready, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata, mem_wd, mem_rd;
  logic [29:0] mem_addr;
  logic [3:0]  mem_we;

  logic        p_c_ready, p_c_rvalid, p_c_err, p_d_ready, p_d_rvalid, p_d_err;
  logic [31:0] p_c_rdata, p_d_rdata, p_mem_wd, p_mem_rd;
  logic [29:0] p_mem_addr;
  logic [3:0]  p_mem_we;
  assign p_mem_rd = 32'd0;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.PRIO_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_addr_i(c_addr), .c_we_i(c_we),
    .c_wdata_i(c_wdata), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata), .c_err_o(c_err),
    .d_valid_i(d_valid), .d_ready_o(d_ready), .d_addr_i(d_addr), .d_we_i(d_we),
    .d_wdata_i(d_wdata), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  data_mem_arbiter #(.PRIO_MODE(1)) u_prio (
    .clk(clk), .rst_n(rst_n),
    .c_valid_i(c_valid), .c_ready_o(p_c_ready), .c_addr_i(c_addr), .c_we_i(c_we),
    .c_wdata_i(c_wdata), .c_rvalid_o(p_c_rvalid), .c_rdata_o(p_c_rdata), .c_err_o(p_c_err),
    .d_valid_i(d_valid), .d_ready_o(p_d_ready), .d_addr_i(d_addr), .d_we_i(d_we),
    .d_wdata_i(d_wdata), .d_rvalid_o(p_d_rvalid), .d_rdata_o(p_d_rdata), .d_err_o(p_d_err),
    .mem_addr_o(p_mem_addr), .mem_we_o(p_mem_we), .mem_wd_o(p_mem_wd), .mem_rd_i(p_mem_rd)
  );

  // DataRam port A: byte-enabled write, 1-cycle synchronous read
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wd[8*i +: 8];
    mem_rd <= ram[mem_addr[7:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: an access covers popcount(we) consecutive bytes starting at addr%4;
  // running past byte 3 is an error and leaves memory untouched.
  task automatic model_apply(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                             output logic [3:0] e_we, output logic [31:0] e_wd,
                             output logic e_err, output logic [31:0] e_rd);
    int n, off, idx;
    logic [63:0] prod;
    n    = $countones(we);
    off  = int'(addr[1:0]);
    idx  = int'(addr[9:2]);
    e_rd = ref_mem[idx];
    e_we = 4'b0000;
    e_err = 1'b0;
    prod = 64'(wd) * (64'd1 << (8 * off));
    e_wd = prod[31:0];
    if (n > 0 && off + n > 4) e_err = 1'b1;
    else
      for (int i = 0; i < n; i++) begin
        e_we[off + i] = 1'b1;
        ref_mem[idx][8*(off + i) +: 8] = wd[8*i +: 8];
      end
  endtask

  task automatic drive(input bit who, input bit v, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] wd);
    if (who) begin d_valid = v; d_addr = a; d_we = w; d_wdata = wd; end
    else     begin c_valid = v; c_addr = a; c_we = w; c_wdata = wd; end
  endtask

  task automatic txn(input bit who, input logic [31:0] addr, input logic [3:0] we,
                     input logic [31:0] wd);
    logic [3:0]  e_we;
    logic [31:0] e_wd, e_rd;
    logic        e_err;
    int n = 0;
    @(negedge clk);
    drive(who, 1'b1, addr, we, wd);
    #1;
    while (!(who ? d_ready : c_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      check_val("ready_timeout", 32'd1, 32'd0);
      drive(who, 1'b0, addr, we, wd);
      return;
    end
    check_val("other_ready", 32'(who ? c_ready : d_ready), 32'd0);
    model_apply(addr, we, wd, e_we, e_wd, e_err, e_rd);
    @(posedge clk); #1;
    drive(who, 1'b0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    check_val("mem_addr", 32'(mem_addr), 32'(addr[31:2]));
    check_val("mem_we", 32'(mem_we), 32'(e_we));
    check_val("mem_wd", mem_wd, e_wd);
    @(negedge clk);
    check_val("own_rvalid", 32'(who ? d_rvalid : c_rvalid), 32'd1);
    check_val("oth_rvalid", 32'(who ? c_rvalid : d_rvalid), 32'd0);
    check_val("own_err", 32'(who ? d_err : c_err), 32'(e_err));
    check_val("oth_rdata", who ? c_rdata : d_rdata, 32'd0);
    if (we == 4'b0000) check_val("rdata", who ? d_rdata : c_rdata, e_rd);
    @(negedge clk);
    check_val("rvalid_pulse", 32'({c_rvalid, d_rvalid}), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int n, g, bad;
    logic [3:0] we_tab [4];
    we_tab[0] = 4'b0000; we_tab[1] = 4'b0001; we_tab[2] = 4'b0011; we_tab[3] = 4'b1111;
    foreach (ram[i]) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_val("rst_c_ready", 32'(c_ready), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_mem_wd", mem_wd, 32'd0);
    check_val("rst_rvalid", 32'({c_rvalid, d_rvalid, c_err, d_err}), 32'd0);
    c_valid = 1'b0;
    rst_n = 1'b1;

    // word write then read, byte store, misaligned half
    txn(0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    txn(0, 32'h0000_0100, 4'b0000, 32'h0);
    txn(0, 32'h0000_0103, 4'b0001, 32'h0000_00AA);
    txn(1, 32'h0000_0203, 4'b0011, 32'h0000_1234);
    check_val("mis_ram_unchanged", ram[8'h80], 32'd0);
    txn(1, 32'h0000_0200, 4'b0000, 32'h0);
    txn(1, 32'h0000_0100, 4'b0000, 32'h0);

    // reset during ISSUE of a word write (word 0xFC is kept out of random traffic)
    @(negedge clk);
    drive(0, 1'b1, 32'h0000_03F0, 4'b1111, 32'h1111_2222);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check_val("mid_issue_we", 32'(mem_we), 32'hF);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_we", 32'(mem_we), 32'd0);
    check_val("mid_rst_rvalid", 32'(c_rvalid), 32'd0);
    check_val("mid_rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("no_replay", 32'({c_rvalid, d_rvalid}), 32'd0);
    end
    drive(0, 1'b1, 32'h0, 4'h0, 32'h0);
    #1;
    check_val("idle_after_rst", 32'(c_ready), 32'd1);
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);

    // contention: both valid for 4 grants
    pulse_reset();
    drive(0, 1'b1, 32'h0000_0100, 4'b0000, 32'h0);
    drive(1, 1'b1, 32'h0000_0204, 4'b0000, 32'h0);
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(c_ready | d_ready) && n < 10) begin @(negedge clk); #1; n++; end
      check_val("rr_grant", 32'({c_ready, d_ready}), (k % 2 == 0) ? 32'd2 : 32'd1);
      check_val("pr_grant", 32'({p_c_ready, p_d_ready}), 32'd2);
      g = (k % 2);
      @(negedge clk);
      @(negedge clk);
      check_val("rr_owner", 32'({c_rvalid, d_rvalid}), g ? 32'd1 : 32'd2);
      check_val("rr_rdata", g ? d_rdata : c_rdata, g ? ref_mem[8'h81] : ref_mem[8'h40]);
      check_val("pr_owner", 32'({p_c_rvalid, p_d_rvalid}), 32'd2);
      @(negedge clk); #1;
    end
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);

    // random single-requester traffic, upper address bits must pass through
    for (int t = 0; t < 120; t++) begin
      a = $urandom_range(0, 32'h3BF);
      a[31:10] = 22'($urandom);
      w = we_tab[$urandom_range(0, 3)];
      txn(1'($urandom_range(0, 1)), a, w, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (i != 8'hFC && ram[i] !== ref_mem[i]) bad++;
    check_val("ram_image", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
